multicycle_addsub: RTL and testbench
====================================

Name: multicycle_addsub

Overview:
- Parametrised, chunk-serial adder/subtractor. It is the multi-cycle successor to the fixed-width ripple subtractor.
- Each cycle it processes CHUNK bits of a WIDTH-bit operation and ripples the carry between chunks through a register.
- Adds an add/sub mode select, signed-overflow and negative flags, an optional magnitude (absolute-value) correction of negative differences, and valid/ready handshakes on input and output.
- Sits between operand-producing logic and any consumer that can tolerate multi-cycle latency in exchange for a narrow carry chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2 and an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle. N = WIDTH/CHUNK is the number of compute cycles. CHUNK = WIDTH gives a single-cycle compute.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operands and mode are presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  minuend / augend.
- b  input  WIDTH  subtrahend / addend.
- op  input  1  0 = add (a+b), 1 = subtract (a-b).
- abs_en  input  1  on subtract with borrow, output the magnitude b-a instead of the raw result.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum / difference (or magnitude).
- carry_out  output  1  final carry; on subtract, 1 = no borrow (a ≥ b unsigned).
- overflow  output  1  signed two's-complement overflow of the raw operation.
- negative  output  1  subtract only: 1 when a < b unsigned. Always 0 on add.

Behaviour:
- Reset
  - Asynchronous assert, clears state to IDLE.
  - out_valid=0, result=0, carry_out=0, overflow=0, negative=0; in_ready=1 while in IDLE.
  - Reset during CALC or FIX aborts the operation: no out_valid pulse is produced for it.
- States: IDLE, CALC, FIX, DONE. in_ready = (state==IDLE). Inputs are ignored in every other state.
- IDLE
  - On an edge with in_valid & in_ready: register a, b^{WIDTH{op}}, op and abs_en; carry register <= op; chunk index <= 0; go to CALC.
- CALC
  - Each edge adds chunk[idx] of a, the effective b and the carry register.
  - Writes the CHUNK-bit sum into result[idx], updates the carry register, and increments idx.
  - On the edge processing idx = N-1:
    - Set carry_out.
    - overflow = (a_msb == beff_msb) & (res_msb != a_msb).
    - negative = op & ~carry.
    - Next state is FIX if op & abs_en & ~carry, else DONE.
- FIX (one cycle)
  - result <= ~result + 1, a full-width two's complement in a single cycle.
  - Flags are unchanged and describe the raw operation. Go to DONE.
- DONE
  - out_valid=1. result and flags are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid <= 0, go to IDLE.
- Latency
  - out_valid is asserted after N edges following the accept edge, or N+1 edges when FIX runs.
  - Minimum issue interval is N+2 cycles: accept, N compute, 1 DONE/handshake.
- Result register
  - Keeps its last value after the handshake; it is meaningful only while out_valid=1.
- Width rules
  - All arithmetic is modulo 2^WIDTH; the carry is never lost between chunks.
  - Add with abs_en=1 behaves exactly as abs_en=0.
- Edge case
  - FIX on a = 0x0000, b = 0x8000 (WIDTH=16) yields magnitude 0x8000, i.e. the natural modulo result.

Test Plan:
- Add (WIDTH=16, CHUNK=4): a=0x1234, b=0x0FFF, op=0 -> result=0x2233, carry_out=0, overflow=0, negative=0; out_valid rises exactly 4 edges after the accept.
- Subtract, no borrow: a=0x0005, b=0x0003, op=1 -> result=0x0002, carry_out=1, negative=0, overflow=0.
- Subtract with borrow: a=0x0003, b=0x0005, op=1.
  - abs_en=0 -> result=0xFFFE, carry_out=0, negative=1, latency 4.
  - abs_en=1 -> result=0x0002, negative=1, latency 5.
- Overflow and carry across chunks:
  - 0x7FFF+0x0001 -> 0x8000, overflow=1, carry_out=0.
  - 0x8000-0x0001 -> 0x7FFF, overflow=1, carry_out=1.
  - 0xFFFF+0x0001 -> 0x0000, carry_out=1.
- Backpressure and abort:
  - Hold out_ready=0 for 3 cycles in DONE -> result and flags stable, in_ready=0; in_valid pulses in that window are ignored.
  - Assert rst two edges into CALC -> out_valid stays 0, in_ready=1; the next op 0x0010+0x0020 returns 0x0030.
- Single-chunk configuration (WIDTH=8, CHUNK=8): 0xFF+0x01 -> result=0x00, carry_out=1, out_valid 1 edge after the accept.

Source files
------------

// File: rtl/multicycle_addsub_if.sv
// Operand/result handshake bundle for multicycle_addsub.
// The master drives operands and out_ready; the slave (the adder) returns the result and flags.
interface multicycle_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             abs_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             negative;

  modport master (
    output in_valid, a, b, op, abs_en, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, negative
  );

  modport slave (
    input  in_valid, a, b, op, abs_en, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, negative
  );
endinterface

// File: rtl/multicycle_addsub.sv
// Chunk-serial add/subtract: CHUNK bits per cycle, carry rippled through a register,
// with optional magnitude correction of a borrowing subtract.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one chunk per cycle, idx 0..N-1
// FIX   | two's-complement the raw difference into its magnitude
// DONE  | result/flags held until out_ready
module multicycle_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_addsub_if.slave  bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [WIDTH-1:0] RES_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, beff_reg, result_reg;
  logic             op_reg, abs_reg, carry_reg;
  logic             carry_out_reg, overflow_reg, negative_reg;
  logic [IDX_W-1:0] idx;
  logic [CHUNK:0]   chunk_sum;
  logic             last;

  assign last      = (idx == LAST_IDX);
  assign chunk_sum = {1'b0, a_reg[idx*CHUNK +: CHUNK]}
                   + {1'b0, beff_reg[idx*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = CALC;
      CALC: begin
        if (last) begin
          // only a borrowing subtract with abs_en needs the extra negate cycle
          if (op_reg & abs_reg & ~chunk_sum[CHUNK]) state_nxt = FIX;
          else                                      state_nxt = DONE;
        end
      end
      FIX:  state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg         <= '0;
      beff_reg      <= '0;
      result_reg    <= '0;
      op_reg        <= 1'b0;
      abs_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      negative_reg  <= 1'b0;
      idx           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            beff_reg  <= bus.b ^ {WIDTH{bus.op}};
            op_reg    <= bus.op;
            abs_reg   <= bus.abs_en;
            carry_reg <= bus.op;
            idx       <= '0;
          end
        end
        CALC: begin
          result_reg[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_reg                      <= chunk_sum[CHUNK];
          if (last) begin
            carry_out_reg <= chunk_sum[CHUNK];
            overflow_reg  <= (a_reg[WIDTH-1] == beff_reg[WIDTH-1]) &
                             (chunk_sum[CHUNK-1] != a_reg[WIDTH-1]);
            negative_reg  <= op_reg & ~chunk_sum[CHUNK];
          end else begin
            idx <= idx + IDX_ONE;
          end
        end
        FIX: result_reg <= ~result_reg + RES_ONE;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_reg;
  assign bus.carry_out = carry_out_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.negative  = negative_reg;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Scoreboard bench for multicycle_addsub: 16-bit/4-bit-chunk instance plus an 8-bit single-chunk one.
module tb_multicycle_addsub;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        n;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        abs_en;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_addsub_if #(.WIDTH(16)) if16 ();
  multicycle_addsub_if #(.WIDTH(8))  if8 ();

  multicycle_addsub #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
  multicycle_addsub #(.WIDTH(8),  .CHUNK(8)) u_dut8  (.clk(clk), .rst(rst), .bus(if8));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic op, input logic abs_en);
    exp_t        e;
    logic [15:0] be;
    logic [16:0] full;
    be    = op ? ~b : b;
    full  = {1'b0, a} + {1'b0, be} + {16'b0, op};
    e.c   = full[16];
    e.v   = (a[15] == be[15]) && (full[15] != a[15]);
    e.n   = op & ~full[16];
    e.res = (op & abs_en & ~full[16]) ? (16'd0 - full[15:0]) : full[15:0];
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && if16.out_valid && if16.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result",    32'(if16.result),    32'(e.res));
        chk("carry_out", 32'(if16.carry_out), 32'(e.c));
        chk("overflow",  32'(if16.overflow),  32'(e.v));
        chk("negative",  32'(if16.negative),  32'(e.n));
      end
    end
  end

  // called #1 after a rising edge with the DUT in IDLE
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op,
                        input logic abs_en, input exp_t e, input logic hold);
    int lat;
    int n_exp;
    n_exp = 4 + ((op & abs_en & ~e.c) ? 1 : 0);
    sb.push_back(e);
    if16.out_ready = ~hold;
    if16.a         = a;
    if16.b         = b;
    if16.op        = op;
    if16.abs_en    = abs_en;
    if16.in_valid  = 1'b1;
    chk("in_ready_idle", 32'(if16.in_ready), 32'd1);
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    lat = 0;
    while (!if16.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(n_exp));
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        if16.in_valid = 1'b1;
        if16.a        = 16'($urandom);
        if16.b        = 16'($urandom);
        chk("hold_in_ready",  32'(if16.in_ready),  32'd0);
        chk("hold_out_valid", 32'(if16.out_valid), 32'd1);
        chk("hold_result",    32'(if16.result),    32'(e.res));
        chk("hold_flags", 32'({if16.carry_out, if16.overflow, if16.negative}),
            32'({e.c, e.v, e.n}));
        @(posedge clk); #1;
      end
      if16.in_valid  = 1'b0;
      if16.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("back_to_idle", 32'(if16.in_ready), 32'd1);
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic op,
                         input logic abs_en, input logic [7:0] exp_res, input logic exp_c,
                         input logic exp_n, input int exp_lat);
    int lat;
    if8.a        = a;
    if8.b        = b;
    if8.op       = op;
    if8.abs_en   = abs_en;
    if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_latency",   32'(lat),           32'(exp_lat));
    chk("w8_result",    32'(if8.result),    32'(exp_res));
    chk("w8_carry_out", 32'(if8.carry_out), 32'(exp_c));
    chk("w8_negative",  32'(if8.negative),  32'(exp_n));
    @(posedge clk); #1;
    chk("w8_back_to_idle", 32'(if8.in_ready), 32'd1);
  endtask

  vec_t dir[$];

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.op = 1'b0; if16.abs_en = 1'b0;
    if16.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.op = 1'b0; if8.abs_en = 1'b0;
    if8.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(if16.out_valid), 32'd0);
    chk("rst_in_ready",  32'(if16.in_ready),  32'd1);
    chk("rst_result",    32'(if16.result),    32'd0);
    chk("rst_flags", 32'({if16.carry_out, if16.overflow, if16.negative}), 32'd0);
    chk("rst_w8_valid",  32'(if8.out_valid),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // a, b, op, abs_en, {result, carry, overflow, negative}
    dir.push_back('{16'h1234, 16'h0FFF, 1'b0, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0}});
    dir.push_back('{16'h0005, 16'h0003, 1'b1, 1'b0, '{16'h0002, 1'b1, 1'b0, 1'b0}});
    dir.push_back('{16'h0003, 16'h0005, 1'b1, 1'b0, '{16'hFFFE, 1'b0, 1'b0, 1'b1}});
    dir.push_back('{16'h0003, 16'h0005, 1'b1, 1'b1, '{16'h0002, 1'b0, 1'b0, 1'b1}});
    dir.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}});
    dir.push_back('{16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b1, 1'b1, 1'b0}});
    dir.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b0}});
    dir.push_back('{16'h0000, 16'h8000, 1'b1, 1'b1, '{16'h8000, 1'b0, 1'b1, 1'b1}});
    dir.push_back('{16'h0003, 16'h0005, 1'b0, 1'b1, '{16'h0008, 1'b0, 1'b0, 1'b0}});
    foreach (dir[i]) run_op(dir[i].a, dir[i].b, dir[i].op, dir[i].abs_en, dir[i].e, 1'b0);

    // borrowing subtract with magnitude fix, held under backpressure
    run_op(16'h00F0, 16'h0100, 1'b1, 1'b1, '{16'h0010, 1'b0, 1'b0, 1'b1}, 1'b1);

    // abort two edges into CALC
    if16.a = 16'h1111; if16.b = 16'h2222; if16.op = 1'b0; if16.abs_en = 1'b0;
    if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(if16.out_valid), 32'd0);
    chk("abort_in_ready",  32'(if16.in_ready),  32'd1);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(if16.out_valid), 32'd0);
    end
    run_op(16'h0010, 16'h0020, 1'b0, 1'b0, '{16'h0030, 1'b0, 1'b0, 1'b0}, 1'b0);

    for (int k = 0; k < 24; k++) begin
      logic [15:0] ra, rb;
      logic        rop, rabs;
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rop  = 1'($urandom_range(0, 1));
      rabs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rop, rabs, model(ra, rb, rop, rabs), k[2] & k[0]);
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);

    run_op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1);
    run_op8(8'h10, 8'h20, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 2);
    run_op8(8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
